// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer
//   Steps one shared Conv2D engine across a layer: output-channel groups in
//   the outer loop, row tiles in the inner loop. Per tile it loads weights
//   (once per group) and activations, fires the engine with a single pulse,
//   waits for the result and hands the tile to the write-back buffer.
//
//   Optional build macro: CONV_SEQ_WDOG_EN adds a watchdog on the WAIT state
//   (WDOG_CYCLES cycles without conv_valid_out -> err_code 2, done, IDLE).
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   start, abort                    layer start (IDLE only), sync abort
//   cfg_oc_groups, cfg_row_tiles    layer geometry, latched on accepted start
//   busy, done, err_code            status (done is a one-cycle pulse)
//   wt_req/wt_grp/wt_ack            weight load handshake
//   act_req/act_tile/act_ack        activation load handshake
//   conv_valid_in, conv_valid_out   engine fire / result
//   wb_valid/wb_grp/wb_tile/wb_ready write-back handshake
module conv_layer_sequencer #(
  parameter int MAX_OC_GROUPS = 16,
  parameter int MAX_ROW_TILES = 64,
  parameter int GRP_W         = $clog2(MAX_OC_GROUPS + 1),
  parameter int TILE_W        = $clog2(MAX_ROW_TILES + 1)
`ifdef CONV_SEQ_WDOG_EN
  ,
  parameter int WDOG_CYCLES   = 255
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [GRP_W-1:0]  cfg_oc_groups,
  input  logic [TILE_W-1:0] cfg_row_tiles,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic              wt_req,
  output logic [GRP_W-1:0]  wt_grp,
  input  logic              wt_ack,
  output logic              act_req,
  output logic [TILE_W-1:0] act_tile,
  input  logic              act_ack,
  output logic              conv_valid_in,
  input  logic              conv_valid_out,
  output logic              wb_valid,
  output logic [GRP_W-1:0]  wb_grp,
  output logic [TILE_W-1:0] wb_tile,
  input  logic              wb_ready
);

  // state  | meaning
  // IDLE   | waiting for start
  // LOAD_W | weight load for current group
  // LOAD_A | activation load for current tile
  // FIRE   | one-cycle engine trigger
  // WAIT   | waiting for engine result
  // WRITE  | offering tile to write-back
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_LOAD_A, S_FIRE, S_WAIT, S_WRITE
  } state_t;

  state_t            state, state_nxt;
  logic [GRP_W-1:0]  grp, grp_nxt, n_grp;
  logic [TILE_W-1:0] tile, tile_nxt, n_tile;
  logic [1:0]        err, err_nxt;
  logic              done_q, done_nxt;
  logic              cfg_load;

`ifdef CONV_SEQ_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  logic [WDOG_W-1:0] wdog;

  // Counts cycles spent in WAIT; zero on the entry cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               wdog <= '0;
    else if (state != S_WAIT) wdog <= '0;
    else                      wdog <= wdog + WDOG_W'(1);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      grp    <= '0;
      tile   <= '0;
      n_grp  <= '0;
      n_tile <= '0;
      err    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      grp    <= grp_nxt;
      tile   <= tile_nxt;
      err    <= err_nxt;
      done_q <= done_nxt;
      if (cfg_load) begin
        n_grp  <= cfg_oc_groups;
        n_tile <= cfg_row_tiles;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grp_nxt   = grp;
    tile_nxt  = tile;
    err_nxt   = err;
    done_nxt  = 1'b0;
    cfg_load  = 1'b0;
    if (abort) begin
      state_nxt = S_IDLE;
      grp_nxt   = '0;
      tile_nxt  = '0;
    end else begin
      // A result with no tile in flight is flagged but otherwise ignored.
      if (conv_valid_out && state != S_WAIT && err == 2'd0) err_nxt = 2'd3;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_oc_groups != '0 && cfg_row_tiles != '0) begin
              cfg_load  = 1'b1;
              err_nxt   = 2'd0;
              grp_nxt   = '0;
              tile_nxt  = '0;
              state_nxt = S_LOAD_W;
            end else begin
              if (err_nxt == 2'd0) err_nxt = 2'd1;
              done_nxt = 1'b1;
            end
          end
        end
        S_LOAD_W: if (wt_ack)  state_nxt = S_LOAD_A;
        S_LOAD_A: if (act_ack) state_nxt = S_FIRE;
        S_FIRE:   state_nxt = S_WAIT;
        S_WAIT: begin
          if (conv_valid_out) state_nxt = S_WRITE;
`ifdef CONV_SEQ_WDOG_EN
          else if (wdog == WDOG_LAST) begin
            if (err == 2'd0) err_nxt = 2'd2;
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
            grp_nxt   = '0;
            tile_nxt  = '0;
          end
`endif
        end
        S_WRITE: begin
          if (wb_ready) begin
            if (tile != n_tile - TILE_W'(1)) begin
              tile_nxt  = tile + TILE_W'(1);
              state_nxt = S_LOAD_A;
            end else if (grp != n_grp - GRP_W'(1)) begin
              grp_nxt   = grp + GRP_W'(1);
              tile_nxt  = '0;
              state_nxt = S_LOAD_W;
            end else begin
              grp_nxt   = '0;
              tile_nxt  = '0;
              done_nxt  = 1'b1;
              state_nxt = S_IDLE;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign busy          = (state != S_IDLE);
  assign done          = done_q;
  assign err_code      = err;
  assign wt_req        = (state == S_LOAD_W);
  assign act_req       = (state == S_LOAD_A);
  assign conv_valid_in = (state == S_FIRE);
  assign wb_valid      = (state == S_WRITE);
  assign wt_grp        = grp;
  assign act_tile      = tile;
  assign wb_grp        = grp;
  assign wb_tile       = tile;

endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Sequences one shared `Conv2D` engine over a layer of the MobileNetV3-small pipeline. The layer is split into output-channel groups (outer loop) and row tiles (inner loop). For each tile the block loads weights and activations through req/ack handshakes, fires the engine with a single `valid_in` pulse, waits for its `valid_out`, and hands the tile to the write-back buffer over a valid/ready handshake. It sits between the layer controller (start/done) and the conv engine and its buffers.

## Interface
- `MAX_OC_GROUPS`, 16, largest output-channel group count supported.
- `MAX_ROW_TILES`, 64, largest row-tile count supported.
- `GRP_W`, `$clog2(MAX_OC_GROUPS+1)`, width of the group count and index.
- `TILE_W`, `$clog2(MAX_ROW_TILES+1)`, width of the tile count and index.
- `WDOG_CYCLES`, 255, watchdog limit for the WAIT state (used only with `CONV_SEQ_WDOG_EN`).
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to start a layer; sampled only in IDLE.
- `abort`  in  1  synchronous abort; highest priority.
- `cfg_oc_groups`  in  GRP_W  number of groups; latched on an accepted start.
- `cfg_row_tiles`  in  TILE_W  number of tiles per group; latched on an accepted start.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a layer (normal end or error end).
- `err_code`  out  2  0 none, 1 zero config, 2 timeout, 3 spurious conv `valid_out`; sticky.
- `wt_req`  out  1  weight-load request; `wt_grp` (GRP_W) carries the current group.
- `wt_ack`  in  1  weight load complete.
- `act_req`  out  1  activation-load request; `act_tile` (TILE_W) carries the current tile.
- `act_ack`  in  1  activation load complete.
- `conv_valid_in`  out  1  to the engine's `valid_in`.
- `conv_valid_out`  in  1  from the engine's `valid_out`.
- `wb_valid`  out  1  write-back request; `wb_grp` and `wb_tile` carry the tile tag.
- `wb_ready`  in  1  write-back accept.

## Operation
- States: IDLE, LOAD_W, LOAD_A, FIRE, WAIT, WRITE. All outputs are Moore-decoded from state and registers.
- **IDLE**
  - `start`=1 with both cfg values nonzero: latch cfg, clear `err_code`, set grp=0 and tile=0, go to LOAD_W.
  - `start`=1 with either cfg value zero: `err_code`=1, pulse `done`, stay in IDLE.
- **LOAD_W:** `wt_req`=1 until `wt_ack` is sampled high; then go to LOAD_A. An ack in the same cycle as the req counts.
- **LOAD_A:** `act_req`=1 until `act_ack`; then go to FIRE.
- **FIRE:** `conv_valid_in`=1 for exactly one cycle; then go to WAIT.
- **WAIT:** on `conv_valid_out`=1, go to WRITE.
- **WRITE:** `wb_valid`=1 with the tags held stable until `wb_ready`. On the handshake:
  - tile < last: tile++, go to LOAD_A.
  - else grp < last: grp++, tile=0, go to LOAD_W.
  - else: go to IDLE and pulse `done`.
- Acks seen while the matching req is low are ignored.
- `conv_valid_out` outside WAIT: ignored; `err_code`=3 if it is still 0. No state change.
- `err_code` records only the first error until the next accepted start.
- `abort`=1 in any state: next state IDLE, all reqs and valids deassert, counters clear, no `done`, `err_code` unchanged. If `abort` and `start` arrive in the same cycle, `abort` wins.
- `start` while `busy` is ignored. Cfg changes while `busy` are ignored.
- Reset: state IDLE; all outputs 0, including `err_code`; counters 0. Reset mid-layer drops the layer silently.

## Timing
- `start` is sampled at cycle 0; `busy` rises at cycle 1.
- With zero-wait acks and `wb_ready`=1, the engine's 2-cycle latency gives 5 cycles per tile: LOAD_A, FIRE, WAIT×2, WRITE. Each group adds 1 cycle of LOAD_W.
- `busy` stays high for G*(1+5T) cycles.
- `done` is high in the first cycle with `busy`=0.
- Exactly one `conv_valid_in` pulse per tile. There is never a second pulse before the matching `conv_valid_out`.

## Configuration
- `CONV_SEQ_WDOG_EN` defined:
  - A counter runs in WAIT.
  - After WDOG_CYCLES cycles without `conv_valid_out`: `err_code`=2, pulse `done`, go to IDLE.
- `CONV_SEQ_WDOG_EN` undefined:
  - No watchdog counter or logic; WAIT waits indefinitely.
  - `err_code`=2 is never produced.

## Test plan
- G=2, T=3, all acks/ready tied to 1, engine model with latency 2 -> `busy` high 32 cycles; exactly 6 `conv_valid_in` pulses; write-back tags in order (0,0)…(1,2); one `done` pulse; `err_code`=0.
- `wt_ack` delayed 4 cycles, `wb_ready` low 3 cycles on tile 1 -> `wt_req`, `wb_valid` and the tags held stable throughout; total time grows by exactly 7 cycles.
- `cfg_oc_groups`=0 -> `done` pulse in the cycle after `start`, `err_code`=1, `busy` never rises.
- `conv_valid_out` injected during LOAD_A -> `err_code`=3; sequence completes normally with a `done` pulse.
- `abort` asserted in WAIT of tile (1,1), then `start` applied in the same cycle -> IDLE next cycle, no `done`; a later `start` runs a full layer from (0,0).
- With `CONV_SEQ_WDOG_EN`: engine never responds -> `err_code`=2 and a `done` pulse 255 cycles after WAIT entry; `rst_n` low mid-layer -> all outputs 0 immediately.
